fpcvt_rr_sched: RTL

Round-robin scheduler that shares one combinational `FPCVT` converter among `N_REQ` requesters. Each requester presents a 13-bit two's-complement sample with a valid/ready handshake. The block grants one requester at a time, registers the sample, and registers the converter's sign/exponent/significand. It returns the result with the requester ID on a single valid/ready response port. It sits between the sample sources and the downstream floating-point consumer.

---
 rtl/fpcvt_rr_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fpcvt_rr_sched.sv
// Round-robin scheduler sharing one combinational int13 -> (s,e3,f5) converter among N_REQ requesters.
// Optional full-scale result counter behind `FPCVT_RR_SAT_CNT_EN`.

module fpcvt (
  input  logic [12:0] d,
  output logic        s,
  output logic [2:0]  e,
  output logic [4:0]  f
);
  logic [11:0] mag, norm;
  logic [3:0]  lz;
  logic [5:0]  fr;

  always_comb begin
    s = d[12];
    // -4096 has no 12-bit magnitude; clamp it to the largest one
    if (d == 13'h1000)  mag = 12'hfff;
    else if (d[12])     mag = 12'(-d);
    else                mag = d[11:0];

    lz = 4'd12;
    for (int i = 0; i < 12; i++)
      if (mag[i]) lz = 4'(11 - i);

    norm = mag << lz;
    fr   = {1'b0, norm[11:7]} + {5'b0, norm[6]};

    if (lz >= 4'd7) begin
      e = 3'd0;
      f = mag[4:0];
    end else if (fr[5]) begin
      if (lz == 4'd0) begin
        e = 3'd7;
        f = 5'd31;
      end else begin
        e = 3'(4'd8 - lz);
        f = 5'd16;
      end
    end else begin
      e = 3'(4'd7 - lz);
      f = fr[4:0];
    end
  end
endmodule

module fpcvt_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [13*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_s,
  output logic [2:0]            rsp_e,
  output logic [4:0]            rsp_f
`ifdef FPCVT_RR_SAT_CNT_EN
  ,
  output logic [7:0]            sat_count
`endif
);
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t                    state, state_nx;
  logic [ID_W-1:0]           ptr, id_q, winner, idx;
  logic [12:0]               d_q;
  logic                      found;
  logic [N_REQ-1:0][12:0]    req_vec;
  logic                      cv_s;
  logic [2:0]                cv_e;
  logic [4:0]                cv_f;

  assign req_vec = req_data;

  // Iterate from farthest to nearest so the nearest set bit after ptr wins
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k + 1);
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: if (found && !rst) begin
        req_ready = N_REQ'(1) << winner;
        state_nx  = CONV;
      end
      CONV: state_nx = HOLD;
      HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  fpcvt u_cvt (.d(d_q), .s(cv_s), .e(cv_e), .f(cv_f));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= ID_W'(N_REQ - 1);
      d_q    <= '0;
      id_q   <= '0;
      rsp_id <= '0;
      rsp_s  <= 1'b0;
      rsp_e  <= '0;
      rsp_f  <= '0;
    end else begin
      if (state == IDLE && found) begin
        ptr  <= winner;
        id_q <= winner;
        d_q  <= req_vec[winner];
      end
      if (state == CONV) begin
        rsp_id <= id_q;
        rsp_s  <= cv_s;
        rsp_e  <= cv_e;
        rsp_f  <= cv_f;
      end
    end
  end

`ifdef FPCVT_RR_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)
      sat_count <= '0;
    else if (state == CONV && cv_e == 3'd7 && cv_f == 5'd31 && sat_count != 8'hff)
      sat_count <= sat_count + 8'd1;
`endif
endmodule
